// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset PC default and the fetch-queue entry layout for the fetch stage.
package ifu_fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_queue.sv
// In-order fetch buffer: entries are allocated at request time and filled by responses
// in request order; the head is presented to decode once filled. Flush empties it.
module ifu_fetch_queue
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_flush,
  input  logic                          i_alloc,
  input  logic [XLEN-1:0]               i_alloc_pc,
  input  logic                          i_fill,
  input  logic [ILEN-1:0]               i_fill_data,
  input  logic                          i_pop,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic [$clog2(DEPTH):0]        o_pending,
  output logic                          o_head_valid,
  output logic [XLEN-1:0]               o_head_pc,
  output logic [ILEN-1:0]               o_head_instr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fq_entry_t         r_q [DEPTH];
  logic [AW-1:0]     r_alloc_ptr;
  logic [AW-1:0]     r_fill_ptr;
  logic [AW-1:0]     r_head_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_pending;
  logic              w_head_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q         <= '{default: '0};
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_count     <= '0;
      r_pending   <= '0;
    end else if (i_flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_q[k].filled <= 1'b0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_count     <= '0;
      r_pending   <= '0;
    end else begin
      if (i_alloc) begin
        r_q[r_alloc_ptr].pc     <= i_alloc_pc;
        r_q[r_alloc_ptr].filled <= 1'b0;
        r_alloc_ptr             <= r_alloc_ptr + AW'(1);
      end
      if (i_fill) begin
        r_q[r_fill_ptr].instr  <= i_fill_data;
        r_q[r_fill_ptr].filled <= 1'b1;
        r_fill_ptr             <= r_fill_ptr + AW'(1);
      end
      if (i_pop) begin
        r_q[r_head_ptr].filled <= 1'b0;
        r_head_ptr             <= r_head_ptr + AW'(1);
      end
      r_count   <= r_count + CW'(i_alloc) - CW'(i_pop);
      r_pending <= r_pending + CW'(i_alloc) - CW'(i_fill);
    end
  end

  assign w_head_valid = (r_count != '0) && r_q[r_head_ptr].filled;

  // Fields read as zero while nothing is presented, matching the reset view.
  assign o_head_valid = w_head_valid;
  assign o_head_pc    = w_head_valid ? r_q[r_head_ptr].pc    : '0;
  assign o_head_instr = w_head_valid ? r_q[r_head_ptr].instr : '0;
  assign o_count      = r_count;
  assign o_pending    = r_pending;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests, discards
// responses made stale by a redirect and hands buffered instructions to decode.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruction,
  output logic [63:0] id_now_pc,
  output logic [63:0] id_pc_plus_4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [63:0]   r_fetch_pc;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] w_drop_nxt;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_pending;
  logic [CW:0]   w_budget;
  logic          w_accept;
  logic          w_fill;
  logic          w_pop;
  logic          w_head_valid;
  logic [63:0]   w_head_pc;
  logic [31:0]   w_head_instr;

  // Stale in-flight fetches still occupy memory-side slots, so they count against DEPTH.
  assign w_budget       = {1'b0, w_count} + {1'b0, r_drop};
  assign imem_req_valid = !redirect_valid && (w_budget < DEPTH_W);
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_fill         = imem_resp_valid && (r_drop == '0) && !redirect_valid;
  assign w_pop          = w_head_valid && id_ready;

  always_comb begin
    w_drop_nxt = r_drop;
    if (redirect_valid)
      w_drop_nxt = r_drop + w_pending - CW'(imem_resp_valid);
    else if (imem_resp_valid && (r_drop != '0))
      w_drop_nxt = r_drop - CW'(1);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_fetch_pc <= RESET_PC;
      r_drop     <= '0;
    end else begin
      r_drop <= w_drop_nxt;
      if (redirect_valid)
        r_fetch_pc <= align4(redirect_pc);
      else if (w_accept)
        r_fetch_pc <= r_fetch_pc + 64'd4;
    end
  end

  ifu_fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .i_clk        (sys_clk),
    .i_rst        (sys_rst),
    .i_flush      (redirect_valid),
    .i_alloc      (w_accept),
    .i_alloc_pc   (r_fetch_pc),
    .i_fill       (w_fill),
    .i_fill_data  (imem_resp_data),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_pending    (w_pending),
    .o_head_valid (w_head_valid),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr)
  );

  assign id_valid       = w_head_valid;
  assign id_instruction = w_head_instr;
  assign id_now_pc      = w_head_pc;
  assign id_pc_plus_4   = w_head_valid ? w_head_pc + 64'd4 : '0;

endmodule
